// File: rtl/out_port_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : out_port_sched                                               |
// | Description : Output-port scheduler. Round-robin arbitration of five       |
// |               requesters into two one-entry VC buffers, with polarity      |
// |               selecting which VC fills and which drains to the link.       |
// |               Define OUT_SCHED_STATS_EN to build the saturating sent_cnt.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module out_port_sched #(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                polarity,
  input  logic [4:0]          req,
  input  logic [5*DATA_W-1:0] data_in,
  output logic [4:0]          gnt,
  input  logic                out_ready,
  output logic                out_send,
  output logic [DATA_W-1:0]   out_data,
  output logic                full_even,
  output logic                full_odd,
  output logic [15:0]         sent_cnt
);

  localparam int         c_NUM_REQ  = 5;
  localparam logic [2:0] c_PTR_LAST = 3'd4;

  logic [2:0]        ptr_even_q, ptr_even_d;
  logic [2:0]        ptr_odd_q,  ptr_odd_d;
  logic              full_even_q, full_even_d;
  logic              full_odd_q,  full_odd_d;
  logic [DATA_W-1:0] buf_even_q, buf_even_d;
  logic [DATA_W-1:0] buf_odd_q,  buf_odd_d;

  logic [2:0]        w_start;
  logic [2:0]        w_rank_j;
  logic              w_win_found;
  logic [2:0]        w_win_rank;
  logic [2:0]        w_win_slot;
  logic [2:0]        w_win_next;
  logic [DATA_W-1:0] w_win_data;
  logic              w_fill_full;
  logic              w_drain_full;
  logic              w_grant;
  logic [4:0]        w_gnt;
  logic              w_send;

  // Rank r is the r-th name in N,S,E,W,PE order, which sits on req bit 4-r.
  function automatic logic [2:0] f_rank(input logic [2:0] start, input logic [2:0] ofs);
    logic [3:0] sum;
    sum = {1'b0, start} + {1'b0, ofs};
    if (sum >= 4'd5) begin
      sum = sum - 4'd5;
    end
    return sum[2:0];
  endfunction

  always_comb begin
    w_start = polarity ? ptr_odd_q : ptr_even_q;
    if (w_start > c_PTR_LAST) begin
      w_start = 3'd0;
    end
  end

  always_comb begin
    w_win_found = 1'b0;
    w_win_rank  = 3'd0;
    w_rank_j    = 3'd0;
    for (int j = 0; j < c_NUM_REQ; j++) begin
      w_rank_j = f_rank(w_start, 3'(j));
      if (!w_win_found && req[c_PTR_LAST - w_rank_j]) begin
        w_win_found = 1'b1;
        w_win_rank  = w_rank_j;
      end
    end
  end

  assign w_win_slot   = c_PTR_LAST - w_win_rank;
  assign w_win_next   = (w_win_rank == c_PTR_LAST) ? 3'd0 : w_win_rank + 3'd1;
  assign w_win_data   = data_in[w_win_slot*DATA_W +: DATA_W];
  assign w_fill_full  = polarity ? full_odd_q : full_even_q;
  assign w_drain_full = polarity ? full_even_q : full_odd_q;
  assign w_grant      = reset_n && !w_fill_full && w_win_found;
  assign w_send       = reset_n && w_drain_full && out_ready;

  always_comb begin
    w_gnt = 5'b00000;
    if (w_grant) begin
      w_gnt[w_win_slot] = 1'b1;
    end
  end

  always_comb begin
    ptr_even_d  = ptr_even_q;
    ptr_odd_d   = ptr_odd_q;
    full_even_d = full_even_q;
    full_odd_d  = full_odd_q;
    buf_even_d  = buf_even_q;
    buf_odd_d   = buf_odd_q;
    // Drain and fill always address opposite VCs, so these never collide.
    if (w_send) begin
      if (polarity) begin
        full_even_d = 1'b0;
      end else begin
        full_odd_d = 1'b0;
      end
    end
    if (w_grant) begin
      if (polarity) begin
        buf_odd_d  = w_win_data;
        full_odd_d = 1'b1;
        ptr_odd_d  = w_win_next;
      end else begin
        buf_even_d  = w_win_data;
        full_even_d = 1'b1;
        ptr_even_d  = w_win_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_even_q  <= 3'd0;
      ptr_odd_q   <= 3'd0;
      full_even_q <= 1'b0;
      full_odd_q  <= 1'b0;
      buf_even_q  <= '0;
      buf_odd_q   <= '0;
    end else begin
      ptr_even_q  <= ptr_even_d;
      ptr_odd_q   <= ptr_odd_d;
      full_even_q <= full_even_d;
      full_odd_q  <= full_odd_d;
      buf_even_q  <= buf_even_d;
      buf_odd_q   <= buf_odd_d;
    end
  end

  assign gnt       = w_gnt;
  assign out_send  = w_send;
  assign out_data  = reset_n ? (polarity ? buf_even_q : buf_odd_q) : '0;
  assign full_even = full_even_q;
  assign full_odd  = full_odd_q;

`ifdef OUT_SCHED_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;

  always_comb begin
    sent_cnt_d = sent_cnt_q;
    if (w_send && (sent_cnt_q != 16'hFFFF)) begin
      sent_cnt_d = sent_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sent_cnt_q <= 16'h0000;
    end else begin
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign sent_cnt = sent_cnt_q;
`else
  assign sent_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_out_port_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_out_port_sched                                            |
// | Description : Directed and random bench for out_port_sched with a          |
// |               behavioural scheduler model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_out_port_sched;

`ifdef OUT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         polarity;
  logic [4:0]   req;
  logic [319:0] data_in;
  logic [4:0]   gnt;
  logic         out_ready;
  logic         out_send;
  logic [63:0]  out_data;
  logic         full_even;
  logic         full_odd;
  logic [15:0]  sent_cnt;

  out_port_sched #(.DATA_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .polarity  (polarity),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .out_ready (out_ready),
    .out_send  (out_send),
    .out_data  (out_data),
    .full_even (full_even),
    .full_odd  (full_odd),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference state: index 0 = even VC, 1 = odd VC
  int          m_ptr  [2];
  bit          m_full [2];
  logic [63:0] m_buf  [2];
  int          m_cnt;
  logic [63:0] d [5];

  logic [4:0]  obs_gnt;
  logic        obs_send;
  logic [63:0] obs_data;
  logic        obs_fe, obs_fo;
  logic [15:0] obs_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Names in priority order N,S,E,W,PE map to req bits 4..0.
  function automatic int model_pick(input int start, input logic [4:0] rq);
    for (int j = 0; j < 5; j++) begin
      int k = (start + j) % 5;
      if (rq[4-k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_ptr[v]  = 0;
      m_full[v] = 1'b0;
      m_buf[v]  = 64'h0;
    end
    m_cnt = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 5; i++) d[i] = {$urandom, $urandom};
  endtask

  task automatic cycle(input logic rn, input logic pol, input logic [4:0] rq, input logic rdy);
    int          k;
    int          fv, dv;
    logic [4:0]  eg;
    logic        es;
    logic [63:0] ed;
    fv = pol ? 1 : 0;
    dv = 1 - fv;
    reset_n = rn; polarity = pol; req = rq; out_ready = rdy;
    for (int i = 0; i < 5; i++) data_in[i*64 +: 64] = d[i];
    k  = (rn && !m_full[fv]) ? model_pick(m_ptr[fv], rq) : -1;
    eg = (k >= 0) ? (5'b00001 << (4 - k)) : 5'b00000;
    es = rn && m_full[dv] && rdy;
    ed = rn ? m_buf[dv] : 64'h0;
    @(negedge clk);
    obs_gnt = gnt; obs_send = out_send; obs_data = out_data;
    obs_fe = full_even; obs_fo = full_odd; obs_cnt = sent_cnt;
    check("gnt", obs_gnt, eg);
    check("out_send", obs_send, es);
    check("out_data", obs_data, ed);
    check("full_even", obs_fe, m_full[0]);
    check("full_odd", obs_fo, m_full[1]);
    check("sent_cnt", obs_cnt, m_cnt[15:0]);
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (es) begin
        m_full[dv] = 1'b0;
        if (STATS && m_cnt < 65535) m_cnt++;
      end
      if (k >= 0) begin
        m_buf[fv]  = d[4-k];
        m_full[fv] = 1'b1;
        m_ptr[fv]  = (k + 1) % 5;
      end
    end
    #1;
  endtask

  logic [4:0] rr_exp [6];

  initial begin
    rr_exp = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    rand_data();
    reset_n = 1'b0; polarity = 1'b0; req = 5'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) data_in[i*64 +: 64] = d[i];
    @(posedge clk); #1;
    model_reset();
    cycle(1'b0, 1'b0, 5'b11111, 1'b1);

    // round-robin rotation with polarity toggling
    for (int c = 0; c < 12; c++) begin
      rand_data();
      cycle(1'b1, c[0], 5'b11111, 1'b1);
      if (!c[0]) check("rr_even_gnt", obs_gnt, rr_exp[c/2]);
      if (c > 0) check("rr_send", obs_send, 1'b1);
    end

    // single PE flit
    rand_data(); d[0] = 64'hA5;
    cycle(1'b1, 1'b0, 5'b00001, 1'b1);
    check("pe_gnt", obs_gnt, 5'b00001);
    cycle(1'b1, 1'b1, 5'b00000, 1'b1);
    check("pe_send", obs_send, 1'b1);
    check("pe_data", obs_data, 64'hA5);
    cycle(1'b1, 1'b0, 5'b00000, 1'b1);
    check("pe_full_clr", obs_fe, 1'b0);

    // stalled drain
    rand_data();
    cycle(1'b1, 1'b0, 5'b10000, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      cycle(1'b1, c[0], 5'b10000, 1'b0);
      check("stall_full_even", obs_fe, 1'b1);
      check("stall_send", obs_send, 1'b0);
      if (!c[0]) check("stall_gnt", obs_gnt, 5'b00000);
    end
    cycle(1'b1, 1'b1, 5'b00000, 1'b1);
    check("unstall_send", obs_send, 1'b1);
    cycle(1'b1, 1'b0, 5'b10000, 1'b1);
    check("unstall_gnt", obs_gnt, 5'b10000);

    // reset with both buffers full, then independent pointers
    cycle(1'b1, 1'b1, 5'b10000, 1'b0);
    cycle(1'b0, 1'b0, 5'b11111, 1'b1);
    check("rst_gnt", obs_gnt, 5'b00000);
    check("rst_send", obs_send, 1'b0);
    cycle(1'b1, 1'b0, 5'b10000, 1'b1);
    check("rst_full_even", obs_fe, 1'b0);
    check("rst_full_odd", obs_fo, 1'b0);
    check("post_rst_gnt", obs_gnt, 5'b10000);
    cycle(1'b1, 1'b1, 5'b11111, 1'b1);
    check("odd_ptr_gnt", obs_gnt, 5'b10000);
    cycle(1'b1, 1'b0, 5'b11111, 1'b1);
    check("even_ptr_gnt", obs_gnt, 5'b01000);
    cycle(1'b1, 1'b1, 5'b00000, 1'b1);
    cycle(1'b1, 1'b0, 5'b00000, 1'b1);
    check("cnt_three", obs_cnt, STATS ? 16'd3 : 16'd0);

`ifdef OUT_SCHED_STATS_EN
    force dut.sent_cnt_q = 16'hFFFE;
    #1;
    release dut.sent_cnt_q;
    m_cnt = 16'hFFFE;
`endif
    cycle(1'b1, 1'b1, 5'b10000, 1'b1);
    cycle(1'b1, 1'b0, 5'b10000, 1'b1);
    cycle(1'b1, 1'b1, 5'b00000, 1'b1);
    cycle(1'b1, 1'b0, 5'b00000, 1'b1);
    check("cnt_saturate", obs_cnt, STATS ? 16'hFFFF : 16'h0000);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rand_data();
      cycle($urandom_range(0, 49) != 0, 1'($urandom), 5'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/out_port_sched.md
# out_port_sched

- Per-output-port scheduler for the cardinal router.
- Shares one output port among the five input requesters (N, S, E, W, PE) using round-robin arbitration, one rotation pointer per virtual channel (even/odd).
- Owns the port's two one-entry VC output buffers and sequences them by router polarity: one VC is filled internally while the other drains to the downstream link.
- One instance sits at each of the five router output ports, between the input-buffer crossbar and the inter-router link.

## Interface
Parameters:
- DATA_W, 64, flit width in bits.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- polarity  in  1  router phase: 0 = fill even VC / drain odd VC; 1 = fill odd VC / drain even VC.
- req  in  5  requests for this port in the current fill VC; bit order [4]=N, [3]=S, [2]=E, [1]=W, [0]=PE.
- data_in  in  5*DATA_W  requester flits; slice i = data_in[i*DATA_W +: DATA_W].
- gnt  out  5  combinational one-hot grant, same bit order.
- out_ready  in  1  downstream VC buffer can accept a flit.
- out_send  out  1  flit presented and accepted this cycle.
- out_data  out  DATA_W  flit from the drain-VC buffer.
- full_even  out  1  even VC buffer occupied.
- full_odd  out  1  odd VC buffer occupied.
- sent_cnt  out  16  count of flits sent (see Configuration).

## Operation
- Fill VC = polarity ? odd : even. Drain VC = the other VC.
- Each VC has a 3-bit pointer with values 0..4, giving the priority start:
  - 0: N,S,E,W,PE
  - 1: S,E,W,PE,N
  - 2: E,W,PE,N,S
  - 3: W,PE,N,S,E
  - 4: PE,N,S,E,W
- Grant:
  - If the fill-VC buffer is empty at the start of the cycle, gnt is one-hot for the first requester in the fill-VC pointer order.
  - Otherwise gnt = 0.
  - No same-cycle bypass: a buffer that drains this cycle cannot be refilled this cycle.
- On a grant, at the clock edge:
  - The fill-VC buffer captures the winner's data_in slice.
  - Its full flag sets.
  - The fill-VC pointer moves to the position just after the winner (N→1, S→2, E→3, W→4, PE→0).
  - The other VC's pointer is unchanged.
- With no grant, both pointers hold.
- Drain:
  - out_data = drain-VC buffer contents.
  - out_send = drain-VC full AND out_ready.
  - When out_send = 1, the drain-VC buffer full flag clears at the edge. Data is not cleared.
- Fill and drain always target different VCs, so no simultaneous set/clear occurs on one buffer.
- A stalled drain (out_ready = 0) holds the buffer full. That VC grants nothing in its next fill phase until it drains.
- A request that is not granted is not latched. The requester must hold req.

## Timing
- Grant is combinational in the same cycle as req. Flit is stored at the end of that cycle.
- Latency with polarity toggling every cycle and out_ready = 1:
  - grant in cycle T.
  - out_send = 1 with that flit in cycle T+1.
  - full flag clears at the end of T+1.
  - The same VC can grant again in T+2.
- Sustained throughput: one flit per cycle per port, alternating VCs.
- Reset (reset_n = 0 at an edge):
  - Both pointers = 0.
  - full_even = full_odd = 0.
  - Both buffers = 0.
  - sent_cnt = 0.
  - Resulting outputs: gnt, out_send = 0 and out_data = 0 while reset_n is low.
  - Reset during operation discards buffered flits. gnt is forced to 0 during any cycle with reset_n = 0.
- Pointer wrap: the value after 4 is 0, via a PE grant. Pointer values 5..7 are unreachable; if they occur, treat as 0 for the grant.

## Configuration
- OUT_SCHED_STATS_EN defined:
  - sent_cnt increments by 1 at each edge where out_send = 1.
  - It saturates at 16'hFFFF and never wraps.
  - Cleared only by reset.
- Not defined: sent_cnt is tied to 16'h0000 and no counter logic is built. The port remains present.

## Test plan
- Reset, then polarity = 0, req = 5'b11111, out_ready = 1 with polarity toggling:
  - even-VC grants over successive even phases are N, S, E, W, PE, N (10000, 01000, 00100, 00010, 00001, 10000).
  - each flit is sent one cycle after its grant.
- Polarity = 0, req = 5'b00001, data slice 0 = 64'hA5; next cycle polarity = 1, out_ready = 1:
  - gnt = 00001 in the first cycle.
  - out_send = 1 and out_data = 64'hA5 in the second cycle.
  - full_even = 0 after it.
- Fill the even VC, then hold out_ready = 0 for 4 cycles with req = 5'b10000:
  - full_even stays 1.
  - no even-phase grants occur.
  - out_send = 0.
  - after out_ready = 1, the send occurs and the next even phase grants N.
- Independent pointers:
  - Grant N on even (even pointer = 1), then req = 5'b11111 on odd.
  - Odd grants N (odd pointer still 0). The next even phase grants S.
- Assert reset_n = 0 with both buffers full:
  - next cycle full_even = full_odd = 0, out_send = 0, gnt = 0.
  - the first grant after release follows N-first order.
- With OUT_SCHED_STATS_EN: send 3 flits and check sent_cnt = 3. Force-preload the counter to 16'hFFFE and send 2 flits: sent_cnt = 16'hFFFF. Without the macro: sent_cnt = 0 throughout.
